// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: game FSM, move tick and direction commit,
// LFSR food placement verified against the segment scan, eat detection, speed and score.
module snake_game_ctrl #(
  parameter int unsigned SCAN_LEN    = 220,
  parameter logic [23:0] TICK_CYCLES = 24'd2000000,
  parameter logic [23:0] TICK_MIN    = 24'd500000,
  parameter logic [23:0] TICK_STEP   = 24'd50000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [3:0] i_btn,
  output logic [1:0] o_state,
  output logic       o_snake_rst_n,
  output logic       o_tick,
  output logic [1:0] o_dir,
  output logic       o_eat,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_first,
  input  logic       i_pos_last,
  input  logic       i_pos_valid,
  input  logic       i_failure,
  input  logic       i_success,
  output logic [4:0] o_food_x,
  output logic [3:0] o_food_y,
  output logic       o_food_valid,
  output logic [7:0] o_score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_WIN  = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    F_OFF,
    F_FIND,
    F_WAIT,
    F_SCAN,
    F_VALID
  } food_e;

  localparam int unsigned   HW         = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam logic [HW-1:0] HOLD_MAX   = HW'(SCAN_LEN - 1);
  localparam logic [23:0]   STEP_LIMIT = TICK_MIN + TICK_STEP;

  state_e      state_q, state_d;
  food_e       food_q, food_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [23:0] timer_q, timer_d;
  logic [23:0] period_q, period_d;
  logic        tick_q, tick_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  pend_q, pend_d;
  logic        eat_q, eat_d;
  logic [4:0]  food_x_q, food_x_d;
  logic [3:0]  food_y_q, food_y_d;
  logic        food_valid_q, food_valid_d;
  logic [7:0]  score_q, score_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        snake_rst_n_q, snake_rst_n_d;

  logic [4:0]  cand_x;
  logic [3:0]  cand_y;
  logic        cand_ok;
  logic        btn_one;
  logic [1:0]  cand_dir;
  logic        dir_ok;
  logic        head_seen;
  logic        seg_hit;

  always_comb begin
    cand_x    = lfsr_q[4:0];
    cand_y    = lfsr_q[8:5];
    cand_ok   = (cand_x != 5'd0) && (cand_x <= 5'd20) && (cand_y != 4'd0);
    btn_one   = (i_btn != 4'd0) && ((i_btn & (i_btn - 4'd1)) == 4'd0);
    // Direction code equals the bit index of the single pressed button.
    case (i_btn)
      4'b0010: cand_dir = 2'b01;
      4'b0100: cand_dir = 2'b10;
      4'b1000: cand_dir = 2'b11;
      default: cand_dir = 2'b00;
    endcase
    dir_ok    = btn_one && !((cand_dir[1] == dir_q[1]) && (cand_dir[0] != dir_q[0]));
    head_seen = i_pos_valid && i_pos_first;
    seg_hit   = i_pos_valid && (i_pos_x == food_x_q) && (i_pos_y == food_y_q);
  end

  always_comb begin
    state_d  = state_q;
    food_d   = food_q;
    hold_d   = hold_q;
    timer_d  = timer_q;
    period_d = period_q;
    tick_d   = tick_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    eat_d    = 1'b0;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    score_d  = score_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    unique case (state_q)
      ST_IDLE: begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end else if (i_start) begin
          state_d  = ST_PLAY;
          food_d   = F_FIND;
          score_d  = '0;
          period_d = TICK_CYCLES;
          dir_d    = 2'b00;
          pend_d   = 2'b00;
          timer_d  = '0;
          tick_d   = 1'b0;
        end
      end

      ST_PLAY: begin
        if (i_failure) begin
          state_d = ST_OVER;
          tick_d  = 1'b0;
        end else if (i_success) begin
          state_d = ST_WIN;
          tick_d  = 1'b0;
        end else begin
          if (dir_ok) pend_d = cand_dir;
          if (tick_q && head_seen) tick_d = 1'b0;
          // A wrap while the previous request is still pending keeps o_tick high but is not a new move.
          if (timer_q >= period_q - 24'd1) begin
            timer_d = '0;
            tick_d  = 1'b1;
            if (!tick_q) dir_d = pend_q;
          end else begin
            timer_d = timer_q + 24'd1;
          end

          case (food_q)
            F_FIND: begin
              if (cand_ok) begin
                food_x_d = cand_x;
                food_y_d = cand_y;
                food_d   = F_WAIT;
              end
            end
            F_WAIT: begin
              if (head_seen) begin
                if (seg_hit)         food_d = F_FIND;
                else if (i_pos_last) food_d = F_VALID;
                else                 food_d = F_SCAN;
              end
            end
            F_SCAN: begin
              if (i_pos_valid) begin
                if (seg_hit)         food_d = F_FIND;
                else if (i_pos_last) food_d = F_VALID;
              end
            end
            F_VALID: begin
              if (head_seen && seg_hit) begin
                eat_d    = 1'b1;
                food_d   = F_FIND;
                score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                period_d = (period_q >= STEP_LIMIT) ? period_q - TICK_STEP : TICK_MIN;
              end
            end
            default: food_d = food_q;
          endcase
        end
      end

      ST_OVER, ST_WIN: begin
        tick_d = 1'b0;
        if (i_start) begin
          state_d = ST_IDLE;
          hold_d  = '0;
          food_d  = F_OFF;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    food_valid_d  = (food_d == F_VALID);
    snake_rst_n_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      food_q        <= F_OFF;
      hold_q        <= '0;
      timer_q       <= '0;
      period_q      <= TICK_CYCLES;
      tick_q        <= 1'b0;
      dir_q         <= 2'b00;
      pend_q        <= 2'b00;
      eat_q         <= 1'b0;
      food_x_q      <= '0;
      food_y_q      <= '0;
      food_valid_q  <= 1'b0;
      score_q       <= '0;
      lfsr_q        <= LFSR_SEED;
      snake_rst_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      food_q        <= food_d;
      hold_q        <= hold_d;
      timer_q       <= timer_d;
      period_q      <= period_d;
      tick_q        <= tick_d;
      dir_q         <= dir_d;
      pend_q        <= pend_d;
      eat_q         <= eat_d;
      food_x_q      <= food_x_d;
      food_y_q      <= food_y_d;
      food_valid_q  <= food_valid_d;
      score_q       <= score_d;
      lfsr_q        <= lfsr_d;
      snake_rst_n_q <= snake_rst_n_d;
    end
  end

  assign o_state       = state_q;
  assign o_snake_rst_n = snake_rst_n_q;
  assign o_tick        = tick_q;
  assign o_dir         = dir_q;
  assign o_eat         = eat_q;
  assign o_food_x      = food_x_q;
  assign o_food_y      = food_y_q;
  assign o_food_valid  = food_valid_q;
  assign o_score       = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: start hold-off, tick/direction table,
// food search and verification, eating, speed-up to the floor, end states and reset.
module tb_snake_game_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [3:0] i_btn;
  logic [1:0] o_state;
  logic       o_snake_rst_n;
  logic       o_tick;
  logic [1:0] o_dir;
  logic       o_eat;
  logic [4:0] i_pos_x;
  logic [3:0] i_pos_y;
  logic       i_pos_first;
  logic       i_pos_last;
  logic       i_pos_valid;
  logic       i_failure;
  logic       i_success;
  logic [4:0] o_food_x;
  logic [3:0] o_food_y;
  logic       o_food_valid;
  logic [7:0] o_score;

  snake_game_ctrl #(
    .SCAN_LEN    (220),
    .TICK_CYCLES (24'd480),
    .TICK_MIN    (24'd450),
    .TICK_STEP   (24'd20),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_btn         (i_btn),
    .o_state       (o_state),
    .o_snake_rst_n (o_snake_rst_n),
    .o_tick        (o_tick),
    .o_dir         (o_dir),
    .o_eat         (o_eat),
    .i_pos_x       (i_pos_x),
    .i_pos_y       (i_pos_y),
    .i_pos_first   (i_pos_first),
    .i_pos_last    (i_pos_last),
    .i_pos_valid   (i_pos_valid),
    .i_failure     (i_failure),
    .i_success     (i_success),
    .o_food_x      (o_food_x),
    .o_food_y      (o_food_y),
    .o_food_valid  (o_food_valid),
    .o_score       (o_score)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  logic [15:0] m_lfsr;
  logic [1:0] dir_q[$];
  logic [7:0] eat_q[$];
  logic prev_tick = 1'b0;
  logic prev_eat  = 1'b0;

  typedef struct {
    logic [3:0] btn;
    logic [1:0] dir;
  } vec_t;
  vec_t vecs[8];

  // x^16 + x^14 + x^13 + x^11, shifting towards the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic in_board(input logic [15:0] s);
    logic [4:0] x;
    logic [3:0] y;
    x = s[4:0];
    y = s[8:5];
    return (x >= 5'd1) && (x <= 5'd20) && (y >= 4'd1);
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event did not occur as required", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_tick && !prev_tick) begin
        if (dir_q.size() == 0) fail("tick_unexpected");
        else check("tick_dir", {30'd0, o_dir}, {30'd0, dir_q.pop_front()});
      end
      if (o_eat) begin
        check("eat_width", {31'd0, prev_eat}, 32'd0);
        if (eat_q.size() == 0) fail("eat_unexpected");
        else check("eat_score", {24'd0, o_score}, {24'd0, eat_q.pop_front()});
      end
    end
    prev_tick = o_tick;
    prev_eat  = o_eat;
  end

  task automatic seg(input logic [4:0] x, input logic [3:0] y, input logic first, input logic last);
    i_pos_valid = 1'b1;
    i_pos_x     = x;
    i_pos_y     = y;
    i_pos_first = first;
    i_pos_last  = last;
    @(negedge clk);
    i_pos_valid = 1'b0;
    i_pos_first = 1'b0;
    i_pos_last  = 1'b0;
  endtask

  // Called at the negedge when the DUT is searching; predicts and checks the latched candidate.
  task automatic find_food(input string tag, output logic [4:0] fx, output logic [3:0] fy);
    int unsigned n = 0;
    while (!in_board(m_lfsr) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) fail({tag, "_search"});
    fx = m_lfsr[4:0];
    fy = m_lfsr[8:5];
    @(negedge clk);
    check({tag, "_x"}, {27'd0, o_food_x}, {27'd0, fx});
    check({tag, "_y"}, {28'd0, o_food_y}, {28'd0, fy});
    check({tag, "_valid"}, {31'd0, o_food_valid}, 32'd0);
  endtask

  task automatic wait_tick(input string tag, output int unsigned at);
    int unsigned n = 0;
    while (!o_tick && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!o_tick) fail(tag);
    at = cyc;
  endtask

  task automatic clear_tick(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, {31'd0, o_tick}, 32'd1);
    seg(5'd25, 4'd3, 1'b1, 1'b1);
    check({tag, "_drop"}, {31'd0, o_tick}, 32'd0);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, {30'd0, o_state}, 32'd0);
    check({tag, "_snake_rst_n"}, {31'd0, o_snake_rst_n}, 32'd0);
    check({tag, "_tick"}, {31'd0, o_tick}, 32'd0);
    check({tag, "_dir"}, {30'd0, o_dir}, 32'd0);
    check({tag, "_eat"}, {31'd0, o_eat}, 32'd0);
    check({tag, "_food_valid"}, {31'd0, o_food_valid}, 32'd0);
    check({tag, "_score"}, {24'd0, o_score}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r_prev;
    int unsigned r_now;
    logic [1:0]  prev_dir;
    logic [4:0]  fx;
    logic [3:0]  fy;

    vecs[0] = '{4'b0000, 2'b00};  // no press
    vecs[1] = '{4'b0010, 2'b00};  // up is reverse of +y
    vecs[2] = '{4'b0100, 2'b10};  // right accepted
    vecs[3] = '{4'b1000, 2'b10};  // left is reverse of +x
    vecs[4] = '{4'b0010, 2'b01};  // up accepted
    vecs[5] = '{4'b0001, 2'b01};  // down is reverse of -y
    vecs[6] = '{4'b0110, 2'b01};  // multi-press ignored
    vecs[7] = '{4'b1000, 2'b11};  // left accepted

    rst = 1'b1; i_start = 1'b0; i_btn = '0;
    i_pos_x = '0; i_pos_y = '0; i_pos_first = 1'b0; i_pos_last = 1'b0; i_pos_valid = 1'b0;
    i_failure = 1'b0; i_success = 1'b0;
    r_prev = 0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    repeat (218) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    check("start_early", {30'd0, o_state}, 32'd0);
    @(negedge clk);
    i_start = 1'b0;
    check("start_state", {30'd0, o_state}, 32'd1);
    check("start_snake_rst_n", {31'd0, o_snake_rst_n}, 32'd1);

    find_food("food1", fx, fy);
    seg(5'd25, 4'd3, 1'b1, 1'b0);
    seg(fx, fy, 1'b0, 1'b0);
    check("collide_valid", {31'd0, o_food_valid}, 32'd0);
    find_food("food2", fx, fy);
    seg(5'd25, 4'd3, 1'b1, 1'b0);
    seg(5'd26, 4'd4, 1'b0, 1'b0);
    check("verify_mid", {31'd0, o_food_valid}, 32'd0);
    seg(5'd27, 4'd5, 1'b0, 1'b1);
    check("verify_done", {31'd0, o_food_valid}, 32'd1);

    prev_dir = 2'b00;
    for (int i = 0; i < 8; i++) begin
      i_btn = vecs[i].btn;
      repeat (5) @(negedge clk);
      i_btn = '0;
      check("dir_hold", {30'd0, o_dir}, {30'd0, prev_dir});
      dir_q.push_back(vecs[i].dir);
      wait_tick("tick_wait", r_now);
      if (i > 0) check("tick_period", r_now - r_prev, 32'd480);
      r_prev   = r_now;
      prev_dir = vecs[i].dir;
      clear_tick("tick");
    end

    eat_q.push_back(8'd1);
    seg(fx, fy, 1'b1, 1'b1);
    check("eat1_pulse", {31'd0, o_eat}, 32'd1);
    find_food("food3", fx, fy);
    seg(5'd25, 4'd3, 1'b1, 1'b0);
    seg(5'd26, 4'd3, 1'b0, 1'b1);
    check("food3_verified", {31'd0, o_food_valid}, 32'd1);
    dir_q.push_back(2'b11);
    wait_tick("tick_eat1", r_now);
    check("period_step", r_now - r_prev, 32'd460);
    r_prev = r_now;
    clear_tick("eat1");

    eat_q.push_back(8'd2);
    seg(fx, fy, 1'b1, 1'b1);
    check("eat2_pulse", {31'd0, o_eat}, 32'd1);
    find_food("food4", fx, fy);
    dir_q.push_back(2'b11);
    wait_tick("tick_eat2", r_now);
    check("period_floor", r_now - r_prev, 32'd450);
    clear_tick("eat2");

    i_failure = 1'b1; i_success = 1'b1;
    @(negedge clk);
    i_failure = 1'b0; i_success = 1'b0;
    check("both_state", {30'd0, o_state}, 32'd2);
    check("over_tick", {31'd0, o_tick}, 32'd0);
    check("over_snake_rst_n", {31'd0, o_snake_rst_n}, 32'd1);
    check("over_food_x", {27'd0, o_food_x}, {27'd0, fx});
    check("over_score", {24'd0, o_score}, 32'd2);
    pulse_start();
    check("over_to_idle", {30'd0, o_state}, 32'd0);
    check("idle_snake_rst_n", {31'd0, o_snake_rst_n}, 32'd0);
    pulse_start();
    check("idle_hold_restart", {30'd0, o_state}, 32'd0);

    repeat (230) @(negedge clk);
    pulse_start();
    check("restart_state", {30'd0, o_state}, 32'd1);
    check("restart_score", {24'd0, o_score}, 32'd0);
    check("restart_dir", {30'd0, o_dir}, 32'd0);
    i_success = 1'b1;
    @(negedge clk);
    i_success = 1'b0;
    check("win_state", {30'd0, o_state}, 32'd3);
    check("win_snake_rst_n", {31'd0, o_snake_rst_n}, 32'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrst");
    check("dir_queue_left", dir_q.size(), 32'd0);
    check("eat_queue_left", eat_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
